regfile_write_arbiter: RTL and testbench

Sequential write-port controller for the shared dual-core register file (banks A and B, 32 x 32-bit each). It accepts register write requests from core 1 and core 2 through per-core buffered valid/ready ports. Each cycle it issues at most one write per bank, using per-bank round-robin arbitration. Its registered outputs drive the register file's per-bank write address and data inputs, so the two cores never produce racing writes to the same bank.

---
 rtl/regfile_write_arbiter_if.sv | 34 +++
 rtl/regfile_write_arbiter.sv | 237 +++++++++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// ----------------------------------------------------------------------------
// regfile_write_arbiter_if
//   One core's register-write request port toward the write arbiter.
//   Signals:
//     wr_valid  core -> arbiter  write request
//     wr_bank   core -> arbiter  target bank (0 = bank A, 1 = bank B)
//     wr_addr   core -> arbiter  register index (5 bits)
//     wr_data   core -> arbiter  write data (32 bits)
//     wr_ready  arbiter -> core  per-core FIFO can accept
//   Modports: master = core side, slave = arbiter side.
// ----------------------------------------------------------------------------
interface regfile_write_arbiter_if;
  logic        wr_valid;
  logic        wr_bank;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_ready;

  modport master (
    output wr_valid,
    output wr_bank,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_bank,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_write_arbiter
//   Write-port controller for a dual-core shared register file with two banks.
//   Each core feeds a DEPTH-entry FIFO; every cycle the two FIFO heads are
//   arbitrated per bank (round-robin on contention) and at most one write per
//   bank is issued on registered outputs.
//
//   Optional feature macro: ARB_CONFLICT_CNT_EN
//     defined   -> conflict_cnt counts cycles with both heads on the same bank
//                  (saturating at 2^CNT_W-1)
//     undefined -> conflict_cnt is tied to 0
//
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     c1, c2              core write request ports (slave modport)
//     rf_we_a/b           per-bank write strobe, one cycle per write
//     rf_waddr_a/b        per-bank write address (held when strobe is low)
//     rf_wdata_a/b        per-bank write data (held when strobe is low)
//     rf_src_a/b          originating core (0 = core 1, 1 = core 2)
//     conflict_cnt        saturating bank-conflict count
// ----------------------------------------------------------------------------
module regfile_write_arbiter #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  regfile_write_arbiter_if.slave c1,
  regfile_write_arbiter_if.slave c2,
  output logic                   rf_we_a,
  output logic [4:0]             rf_waddr_a,
  output logic [31:0]            rf_wdata_a,
  output logic                   rf_src_a,
  output logic                   rf_we_b,
  output logic [4:0]             rf_waddr_b,
  output logic [31:0]            rf_wdata_b,
  output logic                   rf_src_b,
  output logic [CNT_W-1:0]       conflict_cnt
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic        bank;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_entry_t;

  // Per-core FIFO state, indexed [core]
  wr_entry_t     mem_q    [2][DEPTH];
  wr_entry_t     mem_d    [2][DEPTH];
  logic [AW-1:0] wr_ptr_q [2];
  logic [AW-1:0] wr_ptr_d [2];
  logic [AW-1:0] rd_ptr_q [2];
  logic [AW-1:0] rd_ptr_d [2];
  logic [AW:0]   count_q  [2];
  logic [AW:0]   count_d  [2];
  logic [1:0]    ready_q;
  logic [1:0]    ready_d;

  // Round-robin pointer indexed [bank]: 0 = core 1 favoured, 1 = core 2
  logic [1:0]    rr_ptr_q;
  logic [1:0]    rr_ptr_d;

  // Registered bank outputs, indexed [bank]
  logic [1:0]    we_q;
  logic [1:0]    we_d;
  logic [1:0]    src_q;
  logic [1:0]    src_d;
  logic [4:0]    waddr_q  [2];
  logic [4:0]    waddr_d  [2];
  logic [31:0]   wdata_q  [2];
  logic [31:0]   wdata_d  [2];

  wr_entry_t     req_s    [2];
  wr_entry_t     head_s   [2];
  logic [1:0]    push_s;
  logic [1:0]    grant_s;
  logic [1:0]    head_vld_s;
  logic          same_bank_s;

  assign c1.wr_ready = ready_q[0];
  assign c2.wr_ready = ready_q[1];

  // Gather incoming requests from both core ports
  always_comb begin
    req_s[0]  = '{bank: c1.wr_bank, addr: c1.wr_addr, data: c1.wr_data};
    req_s[1]  = '{bank: c2.wr_bank, addr: c2.wr_addr, data: c2.wr_data};
    push_s[0] = c1.wr_valid & ready_q[0];
    push_s[1] = c2.wr_valid & ready_q[1];
  end

  // Expose the FIFO heads
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      head_vld_s[i] = (count_q[i] != '0);
      head_s[i]     = mem_q[i][rd_ptr_q[i]];
    end
  end

  assign same_bank_s = head_vld_s[0] & head_vld_s[1] &
                       (head_s[0].bank == head_s[1].bank);

  // Per-bank arbitration: only a shared bank needs the round-robin pointer
  always_comb begin
    grant_s  = head_vld_s;
    rr_ptr_d = rr_ptr_q;
    if (same_bank_s) begin
      if (rr_ptr_q[head_s[0].bank] == 1'b0) begin
        grant_s = 2'b01;
      end else begin
        grant_s = 2'b10;
      end
      // Hand priority to the core that just lost
      rr_ptr_d[head_s[0].bank] = ~rr_ptr_q[head_s[0].bank];
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Route granted heads onto their bank outputs; address/data/src hold otherwise
  always_comb begin
    we_d    = 2'b00;
    src_d   = src_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    for (int i = 0; i < 2; i++) begin
      if (grant_s[i]) begin
        we_d[head_s[i].bank]    = 1'b1;
        waddr_d[head_s[i].bank] = head_s[i].addr;
        wdata_d[head_s[i].bank] = head_s[i].data;
        src_d[head_s[i].bank]   = (i == 1);
      end else begin
        we_d = we_d;
      end
    end
  end

  // FIFO push/pop bookkeeping and registered ready
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ready_d  = ready_q;
    for (int i = 0; i < 2; i++) begin
      if (push_s[i]) begin
        mem_d[i][wr_ptr_q[i]] = req_s[i];
        wr_ptr_d[i]           = wr_ptr_q[i] + 1'b1;
      end else begin
        wr_ptr_d[i] = wr_ptr_q[i];
      end
      if (grant_s[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
      end else begin
        rd_ptr_d[i] = rd_ptr_q[i];
      end
      case ({push_s[i], grant_s[i]})
        2'b10:   count_d[i] = count_q[i] + 1'b1;
        2'b01:   count_d[i] = count_q[i] - 1'b1;
        default: count_d[i] = count_q[i];
      endcase
      // Based on the post-edge count, so a same-cycle pop is not credited early
      ready_d[i] = (count_d[i] < FULL_CNT);
    end
  end

  // State registers; reset discards any queued writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          mem_q[i][j] <= '0;
        end
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
        waddr_q[i]  <= 5'd0;
        wdata_q[i]  <= 32'd0;
      end
      ready_q  <= 2'b00;
      rr_ptr_q <= 2'b00;
      we_q     <= 2'b00;
      src_q    <= 2'b00;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      ready_q  <= ready_d;
      rr_ptr_q <= rr_ptr_d;
      we_q     <= we_d;
      src_q    <= src_d;
    end
  end

  assign rf_we_a    = we_q[0];
  assign rf_waddr_a = waddr_q[0];
  assign rf_wdata_a = wdata_q[0];
  assign rf_src_a   = src_q[0];
  assign rf_we_b    = we_q[1];
  assign rf_waddr_b = waddr_q[1];
  assign rf_wdata_b = wdata_q[1];
  assign rf_src_b   = src_q[1];

`ifdef ARB_CONFLICT_CNT_EN
  logic [CNT_W-1:0] conflict_cnt_q;
  logic [CNT_W-1:0] conflict_cnt_d;

  // Saturating count of same-bank head collisions
  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (same_bank_s && (conflict_cnt_q != {CNT_W{1'b1}})) begin
      conflict_cnt_d = conflict_cnt_q + 1'b1;
    end else begin
      conflict_cnt_d = conflict_cnt_q;
    end
  end

  // Conflict counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt_q <= {CNT_W{1'b0}};
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
`else
  assign conflict_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// ----------------------------------------------------------------------------
// tb_regfile_write_arbiter
//   Directed self-checking bench for regfile_write_arbiter (DEPTH=2).
//   Inputs are driven 1 time unit after the rising edge; outputs are sampled
//   at that same point, well away from the edge.
// ----------------------------------------------------------------------------
module tb_regfile_write_arbiter;

`ifdef ARB_CONFLICT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rf_we_a;
  logic [4:0]  rf_waddr_a;
  logic [31:0] rf_wdata_a;
  logic        rf_src_a;
  logic        rf_we_b;
  logic [4:0]  rf_waddr_b;
  logic [31:0] rf_wdata_b;
  logic        rf_src_b;
  logic [15:0] conflict_cnt;

  int checks_cnt = 0;
  int errors_cnt = 0;

  regfile_write_arbiter_if c1_if ();
  regfile_write_arbiter_if c2_if ();

  regfile_write_arbiter #(.DEPTH(2), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .c1           (c1_if),
    .c2           (c2_if),
    .rf_we_a      (rf_we_a),
    .rf_waddr_a   (rf_waddr_a),
    .rf_wdata_a   (rf_wdata_a),
    .rf_src_a     (rf_src_a),
    .rf_we_b      (rf_we_b),
    .rf_waddr_b   (rf_waddr_b),
    .rf_wdata_b   (rf_wdata_b),
    .rf_src_b     (rf_src_b),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  // Register-file model for bank A and a log of bank-B writes
  logic [31:0] rf_a_model [32];
  logic [37:0] b_log [$];

  always @(posedge clk) begin
    if (rf_we_a) rf_a_model[rf_waddr_a] <= rf_wdata_a;
    if (rf_we_b) b_log.push_back({rf_src_b, rf_waddr_b, rf_wdata_b});
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int core, input logic v, input logic bank,
                       input logic [4:0] addr, input logic [31:0] data);
    if (core == 1) begin
      c1_if.wr_valid = v; c1_if.wr_bank = bank; c1_if.wr_addr = addr; c1_if.wr_data = data;
    end else begin
      c2_if.wr_valid = v; c2_if.wr_bank = bank; c2_if.wr_addr = addr; c2_if.wr_data = data;
    end
  endtask

  task automatic idle_all;
    drive(1, 1'b0, 1'b0, 5'd0, 32'd0);
    drive(2, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    int  i1, i2;
    bit  acc1, acc2, full1, full2;
    logic stale;
    logic [37:0] exp_e;

    // ---------------- reset ----------------
    idle_all();
    drive(1, 1'b1, 1'b0, 5'd1, 32'h1234);
    tick(); tick(); tick();
    check_val("rst_we_a", rf_we_a, 1'b0);
    check_val("rst_we_b", rf_we_b, 1'b0);
    check_val("rst_waddr_a", rf_waddr_a, 5'd0);
    check_val("rst_wdata_a", rf_wdata_a, 32'd0);
    check_val("rst_ready1", c1_if.wr_ready, 1'b0);
    check_val("rst_cnt", conflict_cnt, 16'd0);
    idle_all();
    rst_n = 1'b1;
    check_val("rel_ready_pre", c1_if.wr_ready, 1'b0);
    tick();
    check_val("rel_ready1", c1_if.wr_ready, 1'b1);
    check_val("rel_ready2", c2_if.wr_ready, 1'b1);

    // ---------------- single write ----------------
    drive(1, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF);
    tick();
    idle_all();
    check_val("single_early", rf_we_a, 1'b0);
    tick();
    check_val("single_we", rf_we_a, 1'b1);
    check_val("single_addr", rf_waddr_a, 5'd5);
    check_val("single_data", rf_wdata_a, 32'hDEADBEEF);
    check_val("single_src", rf_src_a, 1'b0);
    check_val("single_we_b", rf_we_b, 1'b0);
    tick();
    check_val("single_one_cycle", rf_we_a, 1'b0);
    check_val("single_hold", rf_waddr_a, 5'd5);

    // ---------------- parallel banks ----------------
    drive(1, 1'b1, 1'b0, 5'd3, 32'h11);
    drive(2, 1'b1, 1'b1, 5'd3, 32'h22);
    tick();
    idle_all();
    tick();
    check_val("par_we_a", rf_we_a, 1'b1);
    check_val("par_we_b", rf_we_b, 1'b1);
    check_val("par_data_a", rf_wdata_a, 32'h11);
    check_val("par_data_b", rf_wdata_b, 32'h22);
    check_val("par_src_b", rf_src_b, 1'b1);
    check_val("par_cnt", conflict_cnt, 16'd0);

    // ---------------- same-address conflict ----------------
    drive(1, 1'b1, 1'b0, 5'd7, 32'hAAAA);
    drive(2, 1'b1, 1'b0, 5'd7, 32'hBBBB);
    tick();
    idle_all();
    tick();
    check_val("conf1_we", rf_we_a, 1'b1);
    check_val("conf1_data", rf_wdata_a, 32'hAAAA);
    check_val("conf1_src", rf_src_a, 1'b0);
    tick();
    check_val("conf2_we", rf_we_a, 1'b1);
    check_val("conf2_data", rf_wdata_a, 32'hBBBB);
    check_val("conf2_src", rf_src_a, 1'b1);
    tick();
    check_val("conf_done", rf_we_a, 1'b0);
    check_val("conf_final", rf_a_model[7], 32'hBBBB);
    check_val("conf_cnt", conflict_cnt, CNT_EN ? 16'd1 : 16'd0);

    // ---------------- fairness / backpressure on bank B ----------------
    b_log.delete();
    i1 = 0; i2 = 0; full1 = 1'b0; full2 = 1'b0;
    for (int t = 0; t < 100 && (i1 < 6 || i2 < 6); t++) begin
      if (i1 < 6) drive(1, 1'b1, 1'b1, 5'(i1), 32'h100 + 32'(i1));
      else        drive(1, 1'b0, 1'b0, 5'd0, 32'd0);
      if (i2 < 6) drive(2, 1'b1, 1'b1, 5'(8 + i2), 32'h200 + 32'(i2));
      else        drive(2, 1'b0, 1'b0, 5'd0, 32'd0);
      acc1 = (i1 < 6) && c1_if.wr_ready;
      acc2 = (i2 < 6) && c2_if.wr_ready;
      if (i1 < 6 && !c1_if.wr_ready) full1 = 1'b1;
      if (i2 < 6 && !c2_if.wr_ready) full2 = 1'b1;
      tick();
      if (acc1) i1++;
      if (acc2) i2++;
    end
    idle_all();
    for (int t = 0; t < 40 && b_log.size() < 12; t++) tick();
    check_val("fair_count", 64'(b_log.size()), 64'd12);
    check_val("fair_bp1", full1, 1'b1);
    check_val("fair_bp2", full2, 1'b1);
    for (int k = 0; k < b_log.size() && k < 12; k++) begin
      if ((k % 2) == 0) exp_e = {1'b0, 5'(k / 2), 32'h100 + 32'(k / 2)};
      else              exp_e = {1'b1, 5'(8 + k / 2), 32'h200 + 32'(k / 2)};
      check_val($sformatf("fair_wr%0d", k), b_log[k], exp_e);
    end

    // ---------------- mid-operation reset ----------------
    tick(); tick();
    drive(1, 1'b1, 1'b0, 5'd2, 32'h301);
    drive(2, 1'b1, 1'b0, 5'd2, 32'h311);
    tick();
    drive(1, 1'b1, 1'b0, 5'd2, 32'h302);
    drive(2, 1'b1, 1'b0, 5'd2, 32'h312);
    tick();
    idle_all();
    rst_n = 1'b0;
    #1;
    check_val("mrst_we_a", rf_we_a, 1'b0);
    check_val("mrst_ready1", c1_if.wr_ready, 1'b0);
    check_val("mrst_cnt", conflict_cnt, 16'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    stale = 1'b0;
    for (int t = 0; t < 6; t++) begin
      tick();
      stale = stale | rf_we_a | rf_we_b;
    end
    check_val("mrst_no_stale", stale, 1'b0);
    drive(1, 1'b1, 1'b0, 5'd9, 32'h401);
    drive(2, 1'b1, 1'b0, 5'd9, 32'h402);
    tick();
    idle_all();
    tick();
    check_val("mrst_rr_src", rf_src_a, 1'b0);
    check_val("mrst_rr_data", rf_wdata_a, 32'h401);
    tick();
    check_val("mrst_rr2_src", rf_src_a, 1'b1);
    check_val("mrst_rr2_data", rf_wdata_a, 32'h402);
    check_val("mrst_rr_cnt", conflict_cnt, CNT_EN ? 16'd1 : 16'd0);

    $display("Result: errors=%0d of %0d checks", errors_cnt, checks_cnt);
    $finish;
  end

endmodule
